// File: rtl/gold_code_pkg.sv
// Shared types and defaults for the Gold-code chip generator / checker pair.
package gold_code_pkg;

    // Checker acquisition states.
    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    // Tap delays shared with the generator (cycleA0 / cycleA3).
    localparam int CYCLE_LONG_DEF  = 26;
    localparam int CYCLE_SHORT_DEF = 4;

    // Bits needed to hold the values 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/gold_seq_checker_if.sv
// Chip-stream and status bundle between the link test path and the checker.
interface gold_seq_checker_if #(
    parameter int CNT_W = 16
) ();

    logic             Enable;
    logic             Rx_Chip;
    logic             Resync;
    logic             Clear_Cnt;
    logic             Locked;
    logic             Ref_Chip;
    logic             Chip_Err;
    logic             Lock_Lost;
    logic [CNT_W-1:0] Err_Count;

    // Slicer / register side: supplies chips and controls, observes status.
    modport master (
        output Enable, Rx_Chip, Resync, Clear_Cnt,
        input  Locked, Ref_Chip, Chip_Err, Lock_Lost, Err_Count
    );

    // Checker side.
    modport slave (
        input  Enable, Rx_Chip, Resync, Clear_Cnt,
        output Locked, Ref_Chip, Chip_Err, Lock_Lost, Err_Count
    );

endinterface

// File: rtl/gold_chip_hist.sv
// Chip history shift register for the checker: hist[0] is the newest chip.
// Shifts in either the received chip or the local LFSR prediction (flywheel).
module gold_chip_hist #(
    parameter int CYCLE_LONG  = 26,
    parameter int CYCLE_SHORT = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic shift_en,
    input  logic sel_pred,
    input  logic rx_chip,
    output logic tap_long,
    output logic tap_short,
    output logic all_zero_next
);

    logic [CYCLE_LONG-1:0] hist;
    logic                  shift_data;

    assign tap_long   = hist[CYCLE_LONG-1];
    assign tap_short  = hist[CYCLE_SHORT-1];
    assign shift_data = sel_pred ? (tap_long ^ tap_short) : rx_chip;

    // Zero check on the value the register would hold after this shift, so the
    // FSM can reject an all-zero fill in the same cycle the fill completes.
    assign all_zero_next = ~|{hist[CYCLE_LONG-2:0], shift_data};

    // Shift register: advances only on accepted chips.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= {hist[CYCLE_LONG-2:0], shift_data};
        end
    end

endmodule

// File: rtl/gold_seq_checker.sv
// Receive-side checker for the single-LFSR Gold chip stream
// s[n] = s[n-CYCLE_LONG] ^ s[n-CYCLE_SHORT]. Self-synchronises from received
// chips, verifies, then flywheels while locked and reports chip errors.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_ACQ    | filling history with received chips (fill_cnt)
//  ST_VERIFY | flywheel prediction must match VERIFY_LEN chips in a row
//  ST_LOCK   | flywheel running; errors counted per WIN_LEN-chip window
module gold_seq_checker
    import gold_code_pkg::*;
#(
    parameter int CYCLE_LONG  = CYCLE_LONG_DEF,
    parameter int CYCLE_SHORT = CYCLE_SHORT_DEF,
    parameter int VERIFY_LEN  = 32,
    parameter int WIN_LEN     = 256,
    parameter int ERR_THRESH  = 8,
    parameter int CNT_W       = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    gold_seq_checker_if.slave bus
);

    // Counters only ever hold 0..limit-1: each resets on the chip that hits its limit.
    localparam int FILL_W = clog2(CYCLE_LONG);
    localparam int OK_W   = clog2(VERIFY_LEN);
    localparam int WIN_W  = clog2(WIN_LEN);
    localparam int ERR_W  = clog2(ERR_THRESH);

    state_t            state;
    logic [FILL_W-1:0] fill_cnt;
    logic [OK_W-1:0]   ok_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  err_count_q;
    logic              locked_q;
    logic              ref_chip_q;
    logic              chip_err_q;
    logic              lock_lost_q;

    logic tap_long;
    logic tap_short;
    logic all_zero_next;
    logic pred;
    logic mismatch;
    logic advance;
    logic loss_hit;
    logic err_inc;
    logic sel_pred;

    assign pred     = tap_long ^ tap_short;
    assign mismatch = bus.Rx_Chip ^ pred;
    // Resync abandons the chip on its cycle: nothing advances or gets checked.
    assign advance  = bus.Enable & ~bus.Resync;
    assign loss_hit = (state == ST_LOCK) & mismatch & (err_cnt == ERR_W'(ERR_THRESH - 1));
    assign err_inc  = advance & (state == ST_LOCK) & mismatch;

    gold_chip_hist #(
        .CYCLE_LONG  (CYCLE_LONG),
        .CYCLE_SHORT (CYCLE_SHORT)
    ) u_hist (
        .Clock         (Clock),
        .Reset         (Reset),
        .shift_en      (advance),
        .sel_pred      (sel_pred),
        .rx_chip       (bus.Rx_Chip),
        .tap_long      (tap_long),
        .tap_short     (tap_short),
        .all_zero_next (all_zero_next)
    );

    // History input select: flywheel unless the chip sends us back to acquisition,
    // in which case the received chip seeds the new fill.
    always_comb begin
        sel_pred = 1'b0;
        unique case (state)
            ST_VERIFY: sel_pred = ~mismatch;
            ST_LOCK:   sel_pred = ~loss_hit;
            default:   sel_pred = 1'b0;
        endcase
    end

    // Acquisition FSM with its counters and registered status/pulse outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= ST_ACQ;
            fill_cnt    <= '0;
            ok_cnt      <= '0;
            win_cnt     <= '0;
            err_cnt     <= '0;
            locked_q    <= 1'b0;
            ref_chip_q  <= 1'b0;
            chip_err_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            chip_err_q  <= 1'b0;
            lock_lost_q <= 1'b0;
            if (bus.Enable) begin
                ref_chip_q <= pred;
            end
            if (bus.Resync) begin
                state       <= ST_ACQ;
                fill_cnt    <= '0;
                locked_q    <= 1'b0;
                lock_lost_q <= (state == ST_LOCK);
            end else if (bus.Enable) begin
                unique case (state)
                    ST_ACQ: begin
                        if (fill_cnt == FILL_W'(CYCLE_LONG - 1)) begin
                            fill_cnt <= '0;
                            // An all-zero history would predict zeros forever; refill instead.
                            if (!all_zero_next) begin
                                state  <= ST_VERIFY;
                                ok_cnt <= '0;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    ST_VERIFY: begin
                        if (mismatch) begin
                            chip_err_q <= 1'b1;
                            state      <= ST_ACQ;
                            fill_cnt   <= '0;
                        end else if (ok_cnt == OK_W'(VERIFY_LEN - 1)) begin
                            state    <= ST_LOCK;
                            locked_q <= 1'b1;
                            win_cnt  <= '0;
                            err_cnt  <= '0;
                        end else begin
                            ok_cnt <= ok_cnt + 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        chip_err_q <= mismatch;
                        // Loss wins over the window wrap when both land on the same chip.
                        if (loss_hit) begin
                            lock_lost_q <= 1'b1;
                            locked_q    <= 1'b0;
                            state       <= ST_ACQ;
                            fill_cnt    <= '0;
                        end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                            win_cnt <= '0;
                            err_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            if (mismatch) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_ACQ;
                        fill_cnt <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear beats an error on the same cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_count_q <= '0;
        end else if (bus.Clear_Cnt) begin
            err_count_q <= '0;
        end else if (err_inc && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign bus.Locked    = locked_q;
    assign bus.Ref_Chip  = ref_chip_q;
    assign bus.Chip_Err  = chip_err_q;
    assign bus.Lock_Lost = lock_lost_q;
    assign bus.Err_Count = err_count_q;

endmodule

// File: tb/tb_gold_seq_checker.sv
// Directed bench for gold_seq_checker: a reference generator produces the chip
// stream (26 seed ones, then s[n] = s[n-26] ^ s[n-4]); a vector table drives
// error injection, resync and counter clears with hand-computed expectations.
module tb_gold_seq_checker;

    logic Clock = 1'b0;
    logic Reset;

    gold_seq_checker_if #(.CNT_W(16)) bus ();

    gold_seq_checker #(
        .CYCLE_LONG  (26),
        .CYCLE_SHORT (4),
        .VERIFY_LEN  (32),
        .WIN_LEN     (256),
        .ERR_THRESH  (8),
        .CNT_W       (16)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    logic [25:0] g;
    int          gidx;
    logic        last_true;
    logic        en_r;
    int          ecnt;
    int          clean_bad;

    typedef struct {
        int n_clean;
        bit en;
        bit flip;
        bit rs;
        bit clr;
        bit exp_locked;
        bit exp_err;
        bit exp_lost;
        int exp_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add_vec(input int n, input bit en, input bit flip, input bit rs,
                                    input bit clr, input bit lk, input bit er, input bit ls,
                                    input int cnt);
        vec_t v;
        v.n_clean    = n;
        v.en         = en;
        v.flip       = flip;
        v.rs         = rs;
        v.clr        = clr;
        v.exp_locked = lk;
        v.exp_err    = er;
        v.exp_lost   = ls;
        v.exp_cnt    = cnt;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic chip, input logic rs, input logic clr);
        @(negedge Clock);
        bus.Enable    = en;
        bus.Rx_Chip   = chip;
        bus.Resync    = rs;
        bus.Clear_Cnt = clr;
        @(posedge Clock);
        #1;
    endtask

    // Send the next generator chip (optionally inverted); the generator itself
    // always advances with the true chip.
    task automatic gen_step(input logic flip, input logic rs, input logic clr);
        logic c;
        c = (gidx < 26) ? 1'b1 : (g[25] ^ g[3]);
        g = {g[24:0], c};
        gidx++;
        last_true = c;
        drive(1'b1, c ^ flip, rs, clr);
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        bus.Enable    = 1'b0;
        bus.Rx_Chip   = 1'b0;
        bus.Resync    = 1'b0;
        bus.Clear_Cnt = 1'b0;
        g             = '0;
        gidx          = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        Reset         = 1'b1;
        bus.Enable    = 1'b0;
        bus.Rx_Chip   = 1'b0;
        bus.Resync    = 1'b0;
        bus.Clear_Cnt = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_locked", bus.Locked, 0);
        check("rst_ref_chip", bus.Ref_Chip, 0);
        check("rst_chip_err", bus.Chip_Err, 0);
        check("rst_lock_lost", bus.Lock_Lost, 0);
        check("rst_err_count", bus.Err_Count, 0);

        // 1. Error-free stream: lock exactly on the 58th chip
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            gen_step(1'b0, 1'b0, 1'b0);
            check("t1_locked", bus.Locked, k >= 58);
            check("t1_chip_err", bus.Chip_Err, 0);
            check("t1_lock_lost", bus.Lock_Lost, 0);
            if (k >= 27) check("t1_ref_chip", bus.Ref_Chip, last_true);
        end

        // 2. Random Enable gaps: lock after 58 enabled chips, frozen otherwise
        do_reset();
        ecnt = 0;
        for (int cyc = 0; cyc < 600 && ecnt < 58; cyc++) begin
            en_r = 1'($urandom_range(0, 1));
            if (en_r) begin
                gen_step(1'b0, 1'b0, 1'b0);
                ecnt++;
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            check("t2_locked", bus.Locked, ecnt >= 58);
            if (!en_r) check("t2_idle_pulses", {bus.Chip_Err, bus.Lock_Lost}, 0);
        end
        check("t2_enabled_chips", ecnt, 58);

        // 4/5/6. Vector table; starts at the first locked chip of window 1
        for (int i = 1; i <= 7; i++) add_vec(9, 1, 1, 0, 0, 1, 1, 0, i);
        add_vec(185, 1, 0, 0, 0, 1, 0, 0, 7);
        for (int i = 8; i <= 14; i++) add_vec(0, 1, 1, 0, 0, 1, 1, 0, i);
        add_vec(0, 1, 1, 0, 0, 0, 1, 1, 15);
        add_vec(56, 1, 0, 0, 0, 0, 0, 0, 15);
        add_vec(0, 1, 0, 0, 0, 1, 0, 0, 15);
        add_vec(0, 0, 0, 1, 0, 0, 0, 1, 15);
        add_vec(29, 1, 1, 0, 0, 0, 1, 0, 15);
        add_vec(56, 1, 0, 0, 0, 0, 0, 0, 15);
        add_vec(0, 1, 0, 0, 0, 1, 0, 0, 15);
        add_vec(3, 1, 1, 0, 1, 1, 1, 0, 0);
        for (int i = 1; i <= 6; i++) add_vec(0, 1, 1, 0, 0, 1, 1, 0, i);
        add_vec(245, 1, 1, 0, 0, 0, 1, 1, 7);
        add_vec(57, 1, 0, 0, 0, 1, 0, 0, 7);

        foreach (vq[i]) begin
            clean_bad = 0;
            for (int j = 0; j < vq[i].n_clean; j++) begin
                gen_step(1'b0, 1'b0, 1'b0);
                if (bus.Chip_Err !== 1'b0 || bus.Lock_Lost !== 1'b0) clean_bad++;
            end
            check($sformatf("v%0d_clean_pulses", i), clean_bad, 0);
            if (vq[i].en) gen_step(vq[i].flip, vq[i].rs, vq[i].clr);
            else          drive(1'b0, 1'b0, vq[i].rs, vq[i].clr);
            check($sformatf("v%0d_locked", i), bus.Locked, vq[i].exp_locked);
            check($sformatf("v%0d_chip_err", i), bus.Chip_Err, vq[i].exp_err);
            check($sformatf("v%0d_lock_lost", i), bus.Lock_Lost, vq[i].exp_lost);
            check($sformatf("v%0d_err_count", i), bus.Err_Count, vq[i].exp_cnt);
        end

        // Async reset mid-LOCK: outputs drop without waiting for a clock edge
        #3;
        Reset = 1'b1;
        #1;
        check("arst_locked", bus.Locked, 0);
        check("arst_ref_chip", bus.Ref_Chip, 0);
        check("arst_chip_err", bus.Chip_Err, 0);
        check("arst_lock_lost", bus.Lock_Lost, 0);
        check("arst_err_count", bus.Err_Count, 0);

        // 3. All-zero input never leaves acquisition
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check("t3_locked", bus.Locked, 0);
            check("t3_chip_err", bus.Chip_Err, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
